// File: rtl/latch_xlat_bank_pkg.sv
// Shared types and helpers for the latch_xlat_bank translator slice.
// Defines the output-enable state encoding and the delay counter sizing rule.
package latch_xlat_pkg;

    typedef enum logic [1:0] {
        OFF     = 2'd0,
        TURNON  = 2'd1,
        ON      = 2'd2,
        TURNOFF = 2'd3
    } oe_state_t;

    // The counter must be able to hold the larger delay value itself, and it is never zero bits wide.
    function automatic int dly_cnt_width(input int oe_dly, input int oz_dly);
        int m;
        int w;
        m = (oe_dly > oz_dly) ? oe_dly : oz_dly;
        w = $clog2(m + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/latch_xlat_bank_if.sv
// Capture/output bus of latch_xlat_bank; the slave modport is the translator side.
// Q_PAR exists only when LATCH_XLAT_PARITY_EN is defined.
interface latch_xlat_bank_if #(
    parameter int WIDTH = 9
);
    logic [WIDTH-1:0] D;
    logic             LEN;
    logic             MR;
    logic             OE_;
    logic             Q_RDY;
    logic             OVF_CLR;
    logic [WIDTH-1:0] Q;
    logic             Q_VLD;
    logic             Q_OE;
    logic             FULL;
    logic             OVF;
`ifdef LATCH_XLAT_PARITY_EN
    logic             Q_PAR;

    modport slave  (input  D, LEN, MR, OE_, Q_RDY, OVF_CLR,
                    output Q, Q_VLD, Q_OE, FULL, OVF, Q_PAR);
    modport master (output D, LEN, MR, OE_, Q_RDY, OVF_CLR,
                    input  Q, Q_VLD, Q_OE, FULL, OVF, Q_PAR);
`else
    modport slave  (input  D, LEN, MR, OE_, Q_RDY, OVF_CLR,
                    output Q, Q_VLD, Q_OE, FULL, OVF);
    modport master (output D, LEN, MR, OE_, Q_RDY, OVF_CLR,
                    input  Q, Q_VLD, Q_OE, FULL, OVF);
`endif
endinterface

// File: rtl/latch_xlat_bank_fifo.sv
// Capture buffer for latch_xlat_bank: storage, wrapping pointers, occupancy count.
// A word arriving while full is only accepted if the head leaves in the same cycle.
module latch_xlat_fifo #(
    parameter int EW    = 9,
    parameter int DEPTH = 4
) (
    input  logic          CLK,
    input  logic          RST_,
    input  logic          clr,
    input  logic          push_req,
    input  logic          pop_req,
    input  logic [EW-1:0] wdata,
    output logic [EW-1:0] rdata,
    output logic          full,
    output logic          empty,
    output logic          drop
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          push;
    logic          pop;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign pop   = pop_req && !clr && !empty;
    assign push  = push_req && !clr && (!full || pop);
    assign drop  = push_req && !clr && full && !pop;
    assign rdata = mem[rd_ptr];

    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Contents need no reset: the pointers and count alone decide what is visible.
    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/latch_xlat_bank.sv
// Clocked latch translator: buffered capture, output-enable sequencing, sticky overflow.
// Define LATCH_XLAT_PARITY_EN to store odd parity per entry and drive Q_PAR.
module latch_xlat_bank #(
    parameter int WIDTH  = 9,
    parameter int DEPTH  = 4,
    parameter int OE_DLY = 2,
    parameter int OZ_DLY = 2
) (
    input  logic               CLK,
    input  logic               RST_,
    latch_xlat_bank_if.slave   bus
);
    import latch_xlat_pkg::*;

`ifdef LATCH_XLAT_PARITY_EN
    localparam int EW = WIDTH + 1;
`else
    localparam int EW = WIDTH;
`endif
    localparam int CW = dly_cnt_width(OE_DLY, OZ_DLY);
    localparam logic [CW-1:0] OE_END = CW'(OE_DLY);
    localparam logic [CW-1:0] OZ_END = CW'(OZ_DLY);

    oe_state_t     state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [EW-1:0] wdata;
    logic [EW-1:0] head;
    logic          full;
    logic          empty;
    logic          drop;
    logic          q_vld;
    logic          pop;
    logic          ovf;

`ifdef LATCH_XLAT_PARITY_EN
    assign wdata     = {~^bus.D, bus.D};
    assign bus.Q_PAR = q_vld & head[WIDTH];
`else
    assign wdata = bus.D;
`endif

    assign q_vld     = (state == ON) && !empty;
    assign pop       = q_vld && bus.Q_RDY;
    assign bus.Q     = q_vld ? head[WIDTH-1:0] : '0;
    assign bus.Q_VLD = q_vld;
    assign bus.Q_OE  = (state == ON) || (state == TURNOFF);
    assign bus.FULL  = full;
    assign bus.OVF   = ovf;

    latch_xlat_fifo #(
        .EW    (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK      (CLK),
        .RST_     (RST_),
        .clr      (bus.MR),
        .push_req (bus.LEN),
        .pop_req  (pop),
        .wdata    (wdata),
        .rdata    (head),
        .full     (full),
        .empty    (empty),
        .drop     (drop)
    );

    // A new overflow in the same cycle as OVF_CLR wins, so no drop goes unreported.
    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_)            ovf <= 1'b0;
        else if (bus.MR)      ovf <= 1'b0;
        else if (drop)        ovf <= 1'b1;
        else if (bus.OVF_CLR) ovf <= 1'b0;
    end

    always_ff @(posedge CLK or negedge RST_) begin
        if (!RST_) begin
            state <= OFF;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            OFF: begin
                if (!bus.OE_) begin
                    cnt_nxt   = '0;
                    state_nxt = (OE_DLY == 0) ? ON : TURNON;
                end
            end
            TURNON: begin
                if (bus.OE_) begin
                    state_nxt = OFF;
                    cnt_nxt   = '0;
                end else if (cnt == OE_END) begin
                    state_nxt = ON;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            ON: begin
                if (bus.OE_) begin
                    cnt_nxt   = '0;
                    state_nxt = (OZ_DLY == 0) ? OFF : TURNOFF;
                end
            end
            TURNOFF: begin
                if (!bus.OE_) begin
                    state_nxt = ON;
                    cnt_nxt   = '0;
                end else if (cnt == OZ_END) begin
                    state_nxt = OFF;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = OFF;
                cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_latch_xlat_bank.sv
// Randomized self-checking bench for latch_xlat_bank against a queue-based reference model.
// Also exercises Q_PAR when built with LATCH_XLAT_PARITY_EN.
module tb_latch_xlat_bank;

    localparam int WIDTH  = 9;
    localparam int DEPTH  = 4;
    localparam int OE_DLY = 2;
    localparam int OZ_DLY = 2;

    logic CLK;
    logic RST_;
    int   checks = 0;
    int   errors = 0;

    // Reference model: buffer contents, sticky overflow, and enable phase with remaining delay.
    logic [WIDTH-1:0] mq [$];
    bit               m_ovf;
    int               phase;
    int               rem;

    latch_xlat_bank_if #(.WIDTH(WIDTH)) bus ();

    latch_xlat_bank #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .OE_DLY (OE_DLY),
        .OZ_DLY (OZ_DLY)
    ) dut (
        .CLK  (CLK),
        .RST_ (RST_),
        .bus  (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        mq.delete();
        m_ovf = 1'b0;
        phase = 0;
        rem   = 0;
    endfunction

    // Phases: 0 off, 1 turning on, 2 on, 3 turning off; rem counts down the delay left.
    function automatic void model_step(input logic [WIDTH-1:0] d, input logic len, mr, oe_n, rdy, clr);
        bit vld, full, pop, push, drop;
        vld  = (phase == 2) && (mq.size() != 0);
        full = (mq.size() == DEPTH);
        if (mr) begin
            mq.delete();
            m_ovf = 1'b0;
        end else begin
            pop  = vld && rdy;
            push = len && (!full || pop);
            drop = len && full && !pop;
            if (pop)  void'(mq.pop_front());
            if (push) mq.push_back(d);
            if (drop)     m_ovf = 1'b1;
            else if (clr) m_ovf = 1'b0;
        end
        case (phase)
            0: if (!oe_n) begin
                   if (OE_DLY == 0) phase = 2;
                   else begin phase = 1; rem = OE_DLY; end
               end
            1: if (oe_n) phase = 0;
               else if (rem == 0) phase = 2;
               else rem--;
            2: if (oe_n) begin
                   if (OZ_DLY == 0) phase = 0;
                   else begin phase = 3; rem = OZ_DLY; end
               end
            default: if (!oe_n) phase = 2;
               else if (rem == 0) phase = 0;
               else rem--;
        endcase
    endfunction

    task automatic compare_all();
        bit               vld;
        logic [WIDTH-1:0] exp_q;
        vld   = (phase == 2) && (mq.size() != 0);
        exp_q = '0;
        if (vld) exp_q = mq[0];
        checkOutput("q_vld", bus.Q_VLD, vld);
        checkOutput("q", bus.Q, exp_q);
        checkOutput("q_oe", bus.Q_OE, (phase == 2) || (phase == 3));
        checkOutput("full", bus.FULL, mq.size() == DEPTH);
        checkOutput("ovf", bus.OVF, m_ovf);
`ifdef LATCH_XLAT_PARITY_EN
        checkOutput("q_par", bus.Q_PAR, vld && ($countones(exp_q) % 2 == 0));
`endif
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] d, input logic len, mr, oe_n, rdy, clr);
        bus.D       = d;
        bus.LEN     = len;
        bus.MR      = mr;
        bus.OE_     = oe_n;
        bus.Q_RDY   = rdy;
        bus.OVF_CLR = clr;
        @(posedge CLK);
        model_step(d, len, mr, oe_n, rdy, clr);
        #1;
        compare_all();
    endtask

    initial begin
        logic [WIDTH-1:0] words [6];
        bit               oe_n;

        RST_ = 1'b0;
        bus.D = '0; bus.LEN = 0; bus.MR = 0; bus.OE_ = 1; bus.Q_RDY = 0; bus.OVF_CLR = 0;
        model_reset();
        #2;
        compare_all();
        #10 RST_ = 1'b1;

        // Enable: pads come on OE_DLY+1 edges after the request is sampled.
        for (int i = 0; i < 4; i++) begin
            applyStimulus('0, 0, 0, 0, 0, 0);
            checkOutput("oe_latency", bus.Q_OE, i == 3);
        end

        applyStimulus(9'h1A5, 1, 0, 0, 0, 0);
        checkOutput("capture_q", bus.Q, 9'h1A5);
        checkOutput("capture_vld", bus.Q_VLD, 1);
        applyStimulus('0, 0, 0, 0, 1, 0);

        // Overflow: six captures into four entries, then drain in order.
        for (int i = 0; i < 6; i++) begin
            words[i] = WIDTH'(9'h040 + i * 9'h011);
            applyStimulus(words[i], 1, 0, 0, 0, 0);
            checkOutput("full_fill", bus.FULL, i >= 3);
            checkOutput("ovf_fill", bus.OVF, i >= 4);
        end
        for (int i = 0; i < 4; i++) begin
            checkOutput("drain_order", bus.Q, words[i]);
            applyStimulus('0, 0, 0, 0, 1, 0);
        end
        applyStimulus('0, 0, 0, 0, 0, 1);
        checkOutput("ovf_clr", bus.OVF, 0);

        // Full with simultaneous capture and accept.
        for (int i = 0; i < 4; i++) applyStimulus(WIDTH'(9'h100 + i), 1, 0, 0, 0, 0);
        applyStimulus(9'h0EE, 1, 0, 0, 1, 0);
        checkOutput("full_swap_full", bus.FULL, 1);
        checkOutput("full_swap_ovf", bus.OVF, 0);
        for (int i = 0; i < 4; i++) applyStimulus('0, 0, 0, 0, 1, 0);
        checkOutput("full_swap_last", bus.Q, 0);

        // Abort turn-off, then abort turn-on.
        applyStimulus('0, 0, 0, 1, 0, 0);
        checkOutput("turnoff_hold", bus.Q_OE, 1);
        applyStimulus('0, 0, 0, 0, 0, 0);
        checkOutput("turnoff_abort", bus.Q_OE, 1);
        for (int i = 0; i < 4; i++) applyStimulus('0, 0, 0, 1, 0, 0);
        checkOutput("oz_off", bus.Q_OE, 0);
        applyStimulus('0, 0, 0, 0, 0, 0);
        applyStimulus('0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus('0, 0, 0, 1, 0, 0);
            checkOutput("turnon_abort", bus.Q_OE, 0);
        end
        for (int i = 0; i < 4; i++) applyStimulus('0, 0, 0, 0, 0, 0);

        // Master reset with three words held and overflow flagged.
        for (int i = 0; i < 5; i++) applyStimulus(WIDTH'(9'h0A0 + i), 1, 0, 0, 0, 0);
        applyStimulus('0, 0, 0, 0, 1, 0);
        checkOutput("mr_pre_ovf", bus.OVF, 1);
        applyStimulus(9'h1FF, 1, 1, 0, 1, 1);
        checkOutput("mr_q", bus.Q, 0);
        checkOutput("mr_vld", bus.Q_VLD, 0);
        checkOutput("mr_ovf", bus.OVF, 0);
        checkOutput("mr_full", bus.FULL, 0);
        checkOutput("mr_qoe", bus.Q_OE, 1);

`ifdef LATCH_XLAT_PARITY_EN
        applyStimulus(9'h003, 1, 0, 0, 0, 0);
        checkOutput("par_003", bus.Q_PAR, 1);
        applyStimulus('0, 0, 0, 0, 1, 0);
        applyStimulus(9'h007, 1, 0, 0, 0, 0);
        checkOutput("par_007", bus.Q_PAR, 0);
        applyStimulus('0, 0, 0, 0, 1, 0);
`endif

        // Random traffic with an asynchronous reset partway through.
        oe_n = 1'b0;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) oe_n = ~oe_n;
            applyStimulus(WIDTH'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 39) == 0,
                          oe_n, 1'($urandom_range(0, 1)), $urandom_range(0, 9) == 0);
            if (i == 400) begin
                @(negedge CLK);
                RST_ = 1'b0;
                #1;
                model_reset();
                compare_all();
                #2 RST_ = 1'b1;
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
